// File: rtl/muldiv_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
//  Module   : muldiv_pkg
//  Purpose  : Shared constants and types for the RV32M multi-cycle
//             multiply/divide sequencer (ex_muldiv_seq and its datapath).
//             Holds the funct3 encodings, the M-extension opcode/funct7
//             match values, the FSM state encoding and the is_div helper.
//  Revision : 1.0  initial release
//----------------------------------------------------------------------------
package muldiv_pkg;

    // funct3 encodings of the M extension
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Decode match values the ID stage uses to raise start_i
    localparam logic [6:0] OPCODE_M  = 7'b0110011;
    localparam logic [6:0] FUNCT7_M  = 7'b0000001;

    // Sequencer states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Divide/remainder group is exactly the funct3 values with bit 2 set
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_dp.sv
`default_nettype none
//----------------------------------------------------------------------------
//  Module   : muldiv_dp
//  Purpose  : Datapath of the multi-cycle multiplier/divider. One 64-bit
//             accumulator/remainder register plus a shared 33-bit
//             add/subtract step. Multiply is shift-add (hi += b when lo[0],
//             then shift right); divide is restoring (shift left, trial
//             subtract, quotient bit enters at lo[0]).
//  Ports    : clk, rst        clock / synchronous active-high reset
//             i_load          load {0, i_a_mag} into acc and i_b_mag into b
//             i_step          perform one multiply or divide iteration
//             i_div_mode      1 = divide step, 0 = multiply step
//             i_a_mag/i_b_mag operand magnitudes
//             i_neg_all       negate the full 64-bit product
//             i_neg_hi/lo     negate remainder (hi) / quotient (lo) half
//             o_fixed         sign-corrected accumulator view
//  Revision : 1.0  initial release
//----------------------------------------------------------------------------
module muldiv_dp #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_div_mode,
    input  logic [XLEN-1:0]   i_a_mag,
    input  logic [XLEN-1:0]   i_b_mag,
    input  logic              i_neg_all,
    input  logic              i_neg_hi,
    input  logic              i_neg_lo,
    output logic [2*XLEN-1:0] o_fixed
);

    localparam logic [XLEN-1:0]   C_ONE_W  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] C_ONE_2W = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;

    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_base;
    logic [XLEN:0]     w_addend;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_acc_next;
    logic [XLEN-1:0]   w_hi_out;
    logic [XLEN-1:0]   w_lo_out;

    assign w_hi = r_acc[2*XLEN-1:XLEN];
    assign w_lo = r_acc[XLEN-1:0];

    always_comb begin
        if (i_div_mode) begin
            // Trial subtract of the divisor from the shifted remainder.
            // The remainder stays below the divisor, so bit XLEN of the
            // difference is a clean borrow flag.
            w_base   = {w_hi, w_lo[XLEN-1]};
            w_addend = ~{1'b0, r_b};
        end else begin
            w_base   = {1'b0, w_hi};
            w_addend = w_lo[0] ? {1'b0, r_b} : '0;
        end
        w_sum = w_base + w_addend + {{XLEN{1'b0}}, i_div_mode};

        if (i_div_mode) begin
            if (!w_sum[XLEN]) begin
                w_acc_next = {w_sum[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
            end else begin
                w_acc_next = {w_base[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            // The carry out of the add shifts down into the high half.
            w_acc_next = {w_sum, w_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_b   <= '0;
        end else if (i_load) begin
            r_acc <= {{XLEN{1'b0}}, i_a_mag};
            r_b   <= i_b_mag;
        end else if (i_step) begin
            r_acc <= w_acc_next;
        end
    end

    assign w_hi_out = i_neg_hi ? (~w_hi + C_ONE_W) : w_hi;
    assign w_lo_out = i_neg_lo ? (~w_lo + C_ONE_W) : w_lo;
    assign o_fixed  = i_neg_all ? (~r_acc + C_ONE_2W) : {w_hi_out, w_lo_out};

endmodule : muldiv_dp
`default_nettype wire

// File: rtl/ex_muldiv_seq.sv
`default_nettype none
//----------------------------------------------------------------------------
//  Module   : ex_muldiv_seq
//  Purpose  : EX-stage sequencer for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/
//             REM/REMU. Latches operands on start, runs 32 datapath
//             iterations, sign-fixes the result and presents it for one
//             cycle. Divide-by-zero and signed overflow resolve at once.
//  Ports    : clk, rst   clock / synchronous active-high reset
//             start_i    M instruction present in EX
//             op_i       funct3
//             rs1_i/rs2_i operands, rd_i destination register
//             flush_i    kill the in-flight operation
//             stall_o    hold IF/ID/EX while an operation is pending
//             busy_o     sequencer not idle
//             valid_o    result_o/rd_o valid this cycle
//             result_o/rd_o  result and its destination (held until next)
//  Revision : 1.0  initial release
//----------------------------------------------------------------------------
module ex_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam logic [XLEN-1:0]  C_ONE     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  C_MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic [4:0]        r_rd;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;

    logic              w_accept;
    logic              w_sign_a;
    logic              w_sign_b;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_op_div;
    logic [2*XLEN-1:0] w_fixed;
    logic [XLEN-1:0]   w_fix_res;

    assign w_accept = (r_state == ST_IDLE) & start_i & ~flush_i;

    // Operand signedness: rs1 for MULH/MULHSU/DIV/REM, rs2 for MULH/DIV/REM
    assign w_sign_a = (op_i == OP_MULH) | (op_i == OP_MULHSU) |
                      (op_i == OP_DIV)  | (op_i == OP_REM);
    assign w_sign_b = (op_i == OP_MULH) | (op_i == OP_DIV) | (op_i == OP_REM);
    assign w_a_neg  = w_sign_a & rs1_i[XLEN-1];
    assign w_b_neg  = w_sign_b & rs2_i[XLEN-1];
    assign w_a_mag  = w_a_neg ? (~rs1_i + C_ONE) : rs1_i;
    assign w_b_mag  = w_b_neg ? (~rs2_i + C_ONE) : rs2_i;

    // Cases answered without iterating; MUL* never lands here
    assign w_div0    = is_div(op_i) & (rs2_i == '0);
    assign w_ovf     = ((op_i == OP_DIV) | (op_i == OP_REM)) &
                       (rs1_i == C_MIN_INT) & (rs2_i == '1);
    assign w_special = w_div0 | w_ovf;

    // op_i[1] separates REM/REMU from DIV/DIVU
    always_comb begin
        w_special_res = '0;
        if (w_div0) begin
            w_special_res = op_i[1] ? rs1_i : '1;
        end else if (w_ovf) begin
            w_special_res = op_i[1] ? '0 : C_MIN_INT;
        end
    end

    assign w_op_div = is_div(r_op);

    muldiv_dp #(
        .XLEN (XLEN)
    ) u_dp (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept & ~w_special),
        .i_step     (r_state == ST_CALC),
        .i_div_mode (w_op_div),
        .i_a_mag    (w_a_mag),
        .i_b_mag    (w_b_mag),
        .i_neg_all  (~w_op_div & r_neg_q),
        .i_neg_hi   (w_op_div & r_neg_r),
        .i_neg_lo   (w_op_div & r_neg_q),
        .o_fixed    (w_fixed)
    );

    // MUL takes the low product half, other multiplies the high half;
    // quotient lives in the low half, remainder in the high half.
    always_comb begin
        if (w_op_div) begin
            w_fix_res = r_op[1] ? w_fixed[2*XLEN-1:XLEN] : w_fixed[XLEN-1:0];
        end else if (r_op == OP_MUL) begin
            w_fix_res = w_fixed[XLEN-1:0];
        end else begin
            w_fix_res = w_fixed[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= OP_MUL;
            r_rd     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else if (flush_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_op    <= op_i;
                        r_rd    <= rd_i;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_rd_out <= rd_i;
                            r_state  <= ST_DONE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_CNT_MAX) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result <= w_fix_res;
                    r_rd_out <= r_rd;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    // A start_i here belongs to the retiring instruction.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Low in DONE so the pipeline advances on the edge the result retires.
    assign stall_o  = ~rst & ~flush_i &
                      (w_accept | (r_state == ST_CALC) | (r_state == ST_FIX));
    assign busy_o   = (r_state != ST_IDLE);
    assign valid_o  = (r_state == ST_DONE) & ~flush_i;
    assign result_o = r_result;
    assign rd_o     = r_rd_out;

endmodule : ex_muldiv_seq
`default_nettype wire

// File: tb/tb_ex_muldiv_seq.sv
`default_nettype none
//----------------------------------------------------------------------------
//  Module   : tb_ex_muldiv_seq
//  Purpose  : Self-checking bench for ex_muldiv_seq. Directed vectors,
//             special cases, flush/reset abort, back-to-back issue and a
//             randomized sweep against an arithmetic reference model.
//  Revision : 1.0  initial release
//----------------------------------------------------------------------------
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_muldiv_seq #(
        .XLEN  (32),
        .CNT_W (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .rd_i     (rd_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    // Reference model: RV32M results from plain 64-bit arithmetic
    function automatic logic [31:0] model_result(input logic [2:0] op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            3'b000: begin p = ua * ub;           return p[31:0];  end
            3'b001: begin p = sa * sb;           return p[63:32]; end
            3'b010: begin p = sa * longint'(ub); return p[63:32]; end
            3'b011: begin p = ua * ub;           return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        if (op >= 3'd4 && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return 34;
    endfunction

    // Issue one instruction and observe it to retirement. Cycle 0 is the
    // cycle start_i is high; lat is the cycle valid_o is seen (-1 = never).
    task automatic run_op(input  logic [2:0]  op,
                          input  logic [31:0] a,
                          input  logic [31:0] b,
                          input  logic [4:0]  rd,
                          output int          lat,
                          output logic [31:0] res,
                          output logic [4:0]  rd_seen,
                          output bit          stall_ok,
                          output bit          one_shot);
        @(negedge clk);
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
        #1 stall_ok = (stall_o === 1'b1);
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = 1;
        while (valid_o !== 1'b1 && lat < 100) begin
            if (stall_o !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 100) lat = -1;
        res     = result_o;
        rd_seen = rd_o;
        if (stall_o !== 1'b0) stall_ok = 1'b0;
        @(posedge clk); #1;
        one_shot = (valid_o === 1'b0) && (result_o === res);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (stall_o !== 1'b0)   begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        n_checks++; if (busy_o !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (valid_o !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result_o); end
        n_checks++; if (rd_o !== 5'h0)      begin n_fail++; $display("FAIL reset_rd: got %h want 0", rd_o); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_multiply();
        logic [2:0]  op  [4] = '{3'b000, 3'b011, 3'b001, 3'b010};
        logic [31:0] a   [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b   [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF};
        int lat; logic [31:0] res; logic [4:0] rdv; bit st_ok; bit one;
        for (int i = 0; i < 4; i++) begin
            run_op(op[i], a[i], b[i], 5'(i + 1), lat, res, rdv, st_ok, one);
            n_checks++; if (res !== exp[i])     begin n_fail++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, exp[i]); end
            n_checks++; if (lat != 34)          begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d want 34", i, lat); end
            n_checks++; if (rdv !== 5'(i + 1))  begin n_fail++; $display("FAIL mul_rd[%0d]: got %0d want %0d", i, rdv, i + 1); end
            n_checks++; if (!st_ok)             begin n_fail++; $display("FAIL mul_stall[%0d]: got profile-bad want high 0..33 low at 34", i); end
            n_checks++; if (!one)               begin n_fail++; $display("FAIL mul_valid_pulse[%0d]: got not-one-cycle want one cycle", i); end
        end
    endtask

    task automatic test_divide();
        logic [2:0]  op  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] a   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] b   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int lat; logic [31:0] res; logic [4:0] rdv; bit st_ok; bit one;
        for (int i = 0; i < 4; i++) begin
            run_op(op[i], a[i], b[i], 5'(i + 10), lat, res, rdv, st_ok, one);
            n_checks++; if (res !== exp[i])     begin n_fail++; $display("FAIL div_result[%0d]: got %h want %h", i, res, exp[i]); end
            n_checks++; if (lat != 34)          begin n_fail++; $display("FAIL div_latency[%0d]: got %0d want 34", i, lat); end
            n_checks++; if (rdv !== 5'(i + 10)) begin n_fail++; $display("FAIL div_rd[%0d]: got %0d want %0d", i, rdv, i + 10); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  op  [5] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b100};
        logic [31:0] a   [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] b   [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
        int lat; logic [31:0] res; logic [4:0] rdv; bit st_ok; bit one;
        for (int i = 0; i < 5; i++) begin
            run_op(op[i], a[i], b[i], 5'(i + 20), lat, res, rdv, st_ok, one);
            n_checks++; if (res !== exp[i])     begin n_fail++; $display("FAIL special_result[%0d]: got %h want %h", i, res, exp[i]); end
            n_checks++; if (lat != 1)           begin n_fail++; $display("FAIL special_latency[%0d]: got %0d want 1", i, lat); end
            n_checks++; if (rdv !== 5'(i + 20)) begin n_fail++; $display("FAIL special_rd[%0d]: got %0d want %0d", i, rdv, i + 20); end
            n_checks++; if (!one)               begin n_fail++; $display("FAIL special_valid_pulse[%0d]: got not-one-cycle want one cycle", i); end
        end
    endtask

    // Abort in the 10th CALC cycle by flush (use_rst=0) or reset (use_rst=1),
    // then issue a new instruction in the following cycle.
    task automatic test_abort(input bit use_rst);
        int lat; logic [31:0] res; logic [4:0] rdv; bit st_ok; bit one;
        logic [31:0] exp;
        bit valid_seen;
        valid_seen = 1'b0;
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b000; rs1_i = 32'd123; rs2_i = 32'd456; rd_i = 5'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (valid_o === 1'b1) valid_seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before[%0d]: got %b want 1", use_rst, busy_o); end
        if (use_rst) rst = 1'b1; else flush_i = 1'b1;
        #1;
        if (!use_rst) begin
            n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall_comb: got %b want 0", stall_o); end
        end
        if (valid_o === 1'b1) valid_seen = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0)  begin n_fail++; $display("FAIL abort_busy_after[%0d]: got %b want 0", use_rst, busy_o); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL abort_stall_after[%0d]: got %b want 0", use_rst, stall_o); end
        n_checks++; if (valid_seen || valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid[%0d]: got valid want none", use_rst); end
        if (use_rst) begin
            n_checks++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL rst_result_cleared: got %h want 0", result_o); end
            n_checks++; if (rd_o !== 5'h0)      begin n_fail++; $display("FAIL rst_rd_cleared: got %h want 0", rd_o); end
        end
        exp = model_result(3'b010, 32'h8765_4321, 32'h0000_1F3D);
        run_op(3'b010, 32'h8765_4321, 32'h0000_1F3D, 5'd17, lat, res, rdv, st_ok, one);
        n_checks++; if (lat != 34)    begin n_fail++; $display("FAIL abort_restart_latency[%0d]: got %0d want 34", use_rst, lat); end
        n_checks++; if (res !== exp)  begin n_fail++; $display("FAIL abort_restart_result[%0d]: got %h want %h", use_rst, res, exp); end
        n_checks++; if (rdv !== 5'd17) begin n_fail++; $display("FAIL abort_restart_rd[%0d]: got %0d want 17", use_rst, rdv); end
    endtask

    task automatic test_back_to_back();
        int t; int t1; int t2;
        logic [31:0] exp1; logic [31:0] exp2;
        exp1 = model_result(3'b100, 32'hFFFF_0000, 32'd9);
        exp2 = model_result(3'b011, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b100; rs1_i = 32'hFFFF_0000; rs2_i = 32'd9; rd_i = 5'd5;
        @(posedge clk); #1;
        start_i = 1'b0;
        t = 1;
        while (valid_o !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
        t1 = t;
        n_checks++; if (t1 != 34)       begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 34", t1); end
        n_checks++; if (result_o !== exp1) begin n_fail++; $display("FAIL b2b_first_result: got %h want %h", result_o, exp1); end
        n_checks++; if (rd_o !== 5'd5)  begin n_fail++; $display("FAIL b2b_first_rd: got %0d want 5", rd_o); end
        // Second instruction arrives in the DONE cycle and stays for the next one
        start_i = 1'b1; op_i = 3'b011; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h0BAD_F00D; rd_i = 5'd9;
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_done_stall: got %b want 0", stall_o); end
        @(posedge clk); #1; t++;
        n_checks++; if (stall_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_cycle: got stall=%b busy=%b want stall=1 busy=0", stall_o, busy_o); end
        @(posedge clk); #1; t++;
        start_i = 1'b0;
        while (valid_o !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
        t2 = t;
        n_checks++; if (t2 - t1 != 35)     begin n_fail++; $display("FAIL b2b_spacing: got %0d want 35", t2 - t1); end
        n_checks++; if (result_o !== exp2) begin n_fail++; $display("FAIL b2b_second_result: got %h want %h", result_o, exp2); end
        n_checks++; if (rd_o !== 5'd9)     begin n_fail++; $display("FAIL b2b_second_rd: got %0d want 9", rd_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat; logic [31:0] res; logic [4:0] rdv; bit st_ok; bit one;
        logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [4:0] rd;
        logic [31:0] exp; int exp_lat;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom_range(1, 31));
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: a = 32'h0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp     = model_result(op, a, b);
            exp_lat = model_latency(op, a, b);
            run_op(op, a, b, rd, lat, res, rdv, st_ok, one);
            n_checks++; if (res !== exp)   begin n_fail++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, exp); end
            n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL rand_latency[%0d] op=%0d: got %0d want %0d", i, op, lat, exp_lat); end
            n_checks++; if (rdv !== rd)    begin n_fail++; $display("FAIL rand_rd[%0d]: got %0d want %0d", i, rdv, rd); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_special();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ex_muldiv_seq
`default_nettype wire
